// File: rtl/spart_ctrl.sv
// Bus-side controller for the SPART UART: register decode, baud-rate strobe,
// one-byte RX buffer and TX holding register. Optional loopback: SPART_CTRL_LOOPBACK_EN.
module spart_ctrl #(
    parameter logic [15:0] DEFAULT_DIV = 16'd325
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       iocs,
    input  logic       iorw,
    input  logic [1:0] ioaddr,
    input  logic [7:0] wr_data,
    output logic [7:0] rd_data,
    output logic       brg_en,
    input  logic       rx_rdy,
    input  logic [7:0] rx_data,
    output logic       clr_rdy,
    input  logic       tx_busy,
    output logic       tx_start,
    output logic [7:0] tx_data
);

    typedef enum logic [1:0] {
        TX_EMPTY = 2'd0,
        TX_FULL  = 2'd1,
        TX_START = 2'd2,
        TX_GUARD = 2'd3
    } tx_state_t;

    tx_state_t   tx_state_r;
    logic [7:0]  tx_hold_r;
    logic [15:0] div_r;
    logic [15:0] cnt_r;
    logic        rx_rdy_q_r;
    logic [7:0]  rx_buf_r;
    logic        rbr_r;
    logic        rx_ovr_r;
    logic        tx_ovr_r;

    logic        rd_s;
    logic        wr_s;
    logic        rd0_s;
    logic        wr0_s;
    logic        wr1_s;
    logic        wr2_s;
    logic        wr3_s;
    logic        tbr_s;
    logic        lb_s;
    logic        ext_rise_s;
    logic        cap_ext_s;
    logic        cap_lb_s;
    logic        cap_s;
    logic [7:0]  cap_byte_s;
    logic [7:0]  status_s;
    logic [15:0] div_lo_wr_s;
    logic [15:0] div_hi_wr_s;

    // Bus access decode and capture-source selection
    always_comb begin
        rd_s        = iocs & iorw;
        wr_s        = iocs & ~iorw;
        rd0_s       = rd_s & (ioaddr == 2'd0);
        wr0_s       = wr_s & (ioaddr == 2'd0);
        wr1_s       = wr_s & (ioaddr == 2'd1);
        wr2_s       = wr_s & (ioaddr == 2'd2);
        wr3_s       = wr_s & (ioaddr == 2'd3);
        tbr_s       = (tx_state_r == TX_EMPTY);
        ext_rise_s  = rx_rdy & ~rx_rdy_q_r;
        cap_ext_s   = ext_rise_s & ~lb_s;
        cap_lb_s    = (tx_state_r == TX_START) & lb_s;
        cap_s       = cap_ext_s | cap_lb_s;
        if (cap_lb_s) begin
            cap_byte_s = tx_hold_r;
        end else begin
            cap_byte_s = rx_data;
        end
        status_s    = {lb_s, 3'b000, tx_ovr_r, rx_ovr_r, tbr_s, rbr_r};
        div_lo_wr_s = {div_r[15:8], wr_data};
        div_hi_wr_s = {wr_data, div_r[7:0]};
    end

`ifdef SPART_CTRL_LOOPBACK_EN
    logic lb_r;

    // Loopback enable, written through bit 7 of the status/clear register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lb_r <= 1'b0;
        end else if (wr1_s) begin
            lb_r <= wr_data[7];
        end else begin
            lb_r <= lb_r;
        end
    end

    assign lb_s = lb_r;
`else
    assign lb_s = 1'b0;
`endif

    // Baud generator: a divisor write always reloads, taking priority over expiry
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_r  <= DEFAULT_DIV;
            cnt_r  <= DEFAULT_DIV - 16'd1;
            brg_en <= 1'b0;
        end else if (wr2_s) begin
            div_r  <= div_lo_wr_s;
            cnt_r  <= div_lo_wr_s - 16'd1;
            brg_en <= 1'b0;
        end else if (wr3_s) begin
            div_r  <= div_hi_wr_s;
            cnt_r  <= div_hi_wr_s - 16'd1;
            brg_en <= 1'b0;
        end else if (div_r == 16'd0) begin
            cnt_r  <= cnt_r;
            brg_en <= 1'b0;
        end else if (cnt_r == 16'd0) begin
            cnt_r  <= div_r - 16'd1;
            brg_en <= 1'b1;
        end else begin
            cnt_r  <= cnt_r - 16'd1;
            brg_en <= 1'b0;
        end
    end

    // Transmit sequencer with registered launch strobe and data
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tx_state_r <= TX_EMPTY;
            tx_hold_r  <= 8'h00;
            tx_start   <= 1'b0;
            tx_data    <= 8'h00;
        end else begin
            case (tx_state_r)
                TX_EMPTY: begin
                    tx_start <= 1'b0;
                    if (wr0_s) begin
                        tx_hold_r  <= wr_data;
                        tx_state_r <= TX_FULL;
                    end else begin
                        tx_state_r <= TX_EMPTY;
                    end
                end
                TX_FULL: begin
                    if (!tx_busy) begin
                        tx_state_r <= TX_START;
                        tx_start   <= ~lb_s;
                        if (!lb_s) begin
                            tx_data <= tx_hold_r;
                        end else begin
                            tx_data <= tx_data;
                        end
                    end else begin
                        tx_state_r <= TX_FULL;
                        tx_start   <= 1'b0;
                    end
                end
                TX_START: begin
                    tx_start   <= 1'b0;
                    tx_state_r <= TX_GUARD;
                end
                TX_GUARD: begin
                    tx_start   <= 1'b0;
                    tx_state_r <= TX_EMPTY;
                end
                default: begin
                    tx_start   <= 1'b0;
                    tx_state_r <= TX_EMPTY;
                end
            endcase
        end
    end

    // Receive capture and overrun/status flags; a set always beats a W1C clear
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_rdy_q_r <= 1'b0;
            clr_rdy    <= 1'b0;
            rx_buf_r   <= 8'h00;
            rbr_r      <= 1'b0;
            rx_ovr_r   <= 1'b0;
            tx_ovr_r   <= 1'b0;
        end else begin
            rx_rdy_q_r <= rx_rdy;
            clr_rdy    <= ext_rise_s;
            if (cap_s) begin
                rx_buf_r <= cap_byte_s;
                rbr_r    <= 1'b1;
            end else if (rd0_s) begin
                rbr_r    <= 1'b0;
            end else begin
                rbr_r    <= rbr_r;
            end
            // A read of the old byte in the capture cycle consumes it, so no overrun
            if (cap_s && rbr_r && !rd0_s) begin
                rx_ovr_r <= 1'b1;
            end else if (wr1_s && wr_data[2]) begin
                rx_ovr_r <= 1'b0;
            end else begin
                rx_ovr_r <= rx_ovr_r;
            end
            if (wr0_s && !tbr_s) begin
                tx_ovr_r <= 1'b1;
            end else if (wr1_s && wr_data[3]) begin
                tx_ovr_r <= 1'b0;
            end else begin
                tx_ovr_r <= tx_ovr_r;
            end
        end
    end

    // Registered read port; holds its value between reads
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_data <= 8'h00;
        end else if (rd_s) begin
            case (ioaddr)
                2'd0:    rd_data <= rx_buf_r;
                2'd1:    rd_data <= status_s;
                2'd2:    rd_data <= div_r[7:0];
                2'd3:    rd_data <= div_r[15:8];
                default: rd_data <= 8'h00;
            endcase
        end else begin
            rd_data <= rd_data;
        end
    end

endmodule

// File: tb/tb_spart_ctrl.sv
// Directed bench for spart_ctrl: cycle table for bus/TX/RX behaviour plus
// hand-written sequences for baud generator timing and mid-operation reset.
module tb_spart_ctrl;

    logic       clk;
    logic       rst;
    logic       iocs;
    logic       iorw;
    logic [1:0] ioaddr;
    logic [7:0] wr_data;
    logic [7:0] rd_data;
    logic       brg_en;
    logic       rx_rdy;
    logic [7:0] rx_data;
    logic       clr_rdy;
    logic       tx_busy;
    logic       tx_start;
    logic [7:0] tx_data;

    int tests;
    int fails;

    spart_ctrl dut (
        .clk     (clk),
        .rst     (rst),
        .iocs    (iocs),
        .iorw    (iorw),
        .ioaddr  (ioaddr),
        .wr_data (wr_data),
        .rd_data (rd_data),
        .brg_en  (brg_en),
        .rx_rdy  (rx_rdy),
        .rx_data (rx_data),
        .clr_rdy (clr_rdy),
        .tx_busy (tx_busy),
        .tx_start(tx_start),
        .tx_data (tx_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic       iocs;
        logic       iorw;
        logic [1:0] addr;
        logic [7:0] wd;
        logic       rxr;
        logic [7:0] rxd;
        logic       busy;
        logic       chk_rd;
        logic [7:0] exp_rd;
        logic       exp_txs;
        logic [7:0] exp_txd;
        logic       exp_clr;
    } vec_t;

    localparam int NV = 43;
    vec_t vecs [NV];

    function automatic vec_t mk(input logic cs, input logic rw, input logic [1:0] a,
                                input logic [7:0] wd, input logic rxr, input logic [7:0] rxd,
                                input logic busy, input logic chk, input logic [7:0] erd,
                                input logic txs, input logic [7:0] txd, input logic clr);
        vec_t v;
        v.iocs = cs; v.iorw = rw; v.addr = a; v.wd = wd;
        v.rxr = rxr; v.rxd = rxd; v.busy = busy;
        v.chk_rd = chk; v.exp_rd = erd; v.exp_txs = txs; v.exp_txd = txd; v.exp_clr = clr;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, want %h", nm, act, exp);
        end
    endtask

    task automatic idle_bus();
        iocs = 1'b0; iorw = 1'b0; ioaddr = 2'd0; wr_data = 8'h00;
    endtask

    task automatic bus_wr(input logic [1:0] a, input logic [7:0] d);
        iocs = 1'b1; iorw = 1'b0; ioaddr = a; wr_data = d;
        @(posedge clk); #1;
        idle_bus();
    endtask

    task automatic bus_rd(input logic [1:0] a, output logic [7:0] d);
        iocs = 1'b1; iorw = 1'b1; ioaddr = a; wr_data = 8'h00;
        @(posedge clk); #1;
        d = rd_data;
        idle_bus();
    endtask

    // Edges until brg_en is seen high; -1 when the bound expires
    task automatic wait_tick(input int bound, output int n);
        int got;
        got = 0;
        n = 0;
        while (got == 0 && n < bound) begin
            @(posedge clk); #1;
            n++;
            if (brg_en === 1'b1) got = 1;
        end
        if (got == 0) n = -1;
    endtask

    initial begin
        logic [7:0] rd;
        int n;
        int ticks;
        int starts;

        tests = 0;
        fails = 0;
        rst = 1'b1;
        rx_rdy = 1'b0; rx_data = 8'h00; tx_busy = 1'b0;
        idle_bus();

        //               cs   rw   a     wd     rxr  rxd    bsy  chk  erd    txs  txd    clr
        vecs[0]  = mk(1'b1,1'b1,2'd1,8'h00, 1'b0,8'h00, 1'b0,1'b1,8'h02, 1'b0,8'h00, 1'b0);
        vecs[1]  = mk(1'b1,1'b1,2'd2,8'h00, 1'b0,8'h00, 1'b0,1'b1,8'h45, 1'b0,8'h00, 1'b0);
        vecs[2]  = mk(1'b1,1'b1,2'd3,8'h00, 1'b0,8'h00, 1'b0,1'b1,8'h01, 1'b0,8'h00, 1'b0);
        vecs[3]  = mk(1'b1,1'b0,2'd0,8'h5A, 1'b0,8'h00, 1'b0,1'b0,8'h00, 1'b0,8'h00, 1'b0);
        vecs[4]  = mk(1'b0,1'b0,2'd0,8'h00, 1'b0,8'h00, 1'b0,1'b0,8'h00, 1'b1,8'h5A, 1'b0);
        vecs[5]  = mk(1'b0,1'b0,2'd0,8'h00, 1'b0,8'h00, 1'b0,1'b0,8'h00, 1'b0,8'h00, 1'b0);
        vecs[6]  = mk(1'b0,1'b0,2'd0,8'h00, 1'b0,8'h00, 1'b0,1'b0,8'h00, 1'b0,8'h00, 1'b0);
        vecs[7]  = mk(1'b1,1'b0,2'd0,8'h11, 1'b0,8'h00, 1'b0,1'b0,8'h00, 1'b0,8'h00, 1'b0);
        vecs[8]  = mk(1'b1,1'b0,2'd0,8'h22, 1'b0,8'h00, 1'b0,1'b0,8'h00, 1'b1,8'h11, 1'b0);
        vecs[9]  = mk(1'b1,1'b1,2'd1,8'h00, 1'b0,8'h00, 1'b0,1'b1,8'h08, 1'b0,8'h00, 1'b0);
        vecs[10] = mk(1'b1,1'b0,2'd1,8'h08, 1'b0,8'h00, 1'b0,1'b0,8'h00, 1'b0,8'h00, 1'b0);
        vecs[11] = mk(1'b1,1'b1,2'd1,8'h00, 1'b0,8'h00, 1'b0,1'b1,8'h02, 1'b0,8'h00, 1'b0);
        vecs[12] = mk(1'b1,1'b0,2'd0,8'h33, 1'b0,8'h00, 1'b1,1'b0,8'h00, 1'b0,8'h00, 1'b0);
        vecs[13] = mk(1'b0,1'b0,2'd0,8'h00, 1'b0,8'h00, 1'b1,1'b0,8'h00, 1'b0,8'h00, 1'b0);
        vecs[14] = mk(1'b1,1'b1,2'd1,8'h00, 1'b0,8'h00, 1'b1,1'b1,8'h00, 1'b0,8'h00, 1'b0);
        vecs[15] = mk(1'b0,1'b0,2'd0,8'h00, 1'b0,8'h00, 1'b1,1'b0,8'h00, 1'b0,8'h00, 1'b0);
        vecs[16] = mk(1'b0,1'b0,2'd0,8'h00, 1'b0,8'h00, 1'b0,1'b0,8'h00, 1'b1,8'h33, 1'b0);
        vecs[17] = mk(1'b0,1'b0,2'd0,8'h00, 1'b0,8'h00, 1'b1,1'b0,8'h00, 1'b0,8'h00, 1'b0);
        vecs[18] = mk(1'b0,1'b0,2'd0,8'h00, 1'b0,8'h00, 1'b1,1'b0,8'h00, 1'b0,8'h00, 1'b0);
        vecs[19] = mk(1'b1,1'b1,2'd1,8'h00, 1'b0,8'h00, 1'b1,1'b1,8'h02, 1'b0,8'h00, 1'b0);
        vecs[20] = mk(1'b0,1'b0,2'd0,8'h00, 1'b1,8'hA1, 1'b0,1'b0,8'h00, 1'b0,8'h00, 1'b1);
        vecs[21] = mk(1'b0,1'b0,2'd0,8'h00, 1'b1,8'hA1, 1'b0,1'b0,8'h00, 1'b0,8'h00, 1'b0);
        vecs[22] = mk(1'b0,1'b0,2'd0,8'h00, 1'b0,8'h00, 1'b0,1'b0,8'h00, 1'b0,8'h00, 1'b0);
        vecs[23] = mk(1'b0,1'b0,2'd0,8'h00, 1'b1,8'hB2, 1'b0,1'b0,8'h00, 1'b0,8'h00, 1'b1);
        vecs[24] = mk(1'b1,1'b1,2'd1,8'h00, 1'b0,8'h00, 1'b0,1'b1,8'h07, 1'b0,8'h00, 1'b0);
        vecs[25] = mk(1'b1,1'b1,2'd0,8'h00, 1'b0,8'h00, 1'b0,1'b1,8'hB2, 1'b0,8'h00, 1'b0);
        vecs[26] = mk(1'b1,1'b1,2'd1,8'h00, 1'b0,8'h00, 1'b0,1'b1,8'h06, 1'b0,8'h00, 1'b0);
        vecs[27] = mk(1'b1,1'b0,2'd1,8'h04, 1'b0,8'h00, 1'b0,1'b0,8'h00, 1'b0,8'h00, 1'b0);
        vecs[28] = mk(1'b0,1'b0,2'd0,8'h00, 1'b1,8'hC3, 1'b0,1'b0,8'h00, 1'b0,8'h00, 1'b1);
        vecs[29] = mk(1'b0,1'b0,2'd0,8'h00, 1'b0,8'h00, 1'b0,1'b0,8'h00, 1'b0,8'h00, 1'b0);
        vecs[30] = mk(1'b1,1'b1,2'd0,8'h00, 1'b1,8'hD4, 1'b0,1'b1,8'hC3, 1'b0,8'h00, 1'b1);
        vecs[31] = mk(1'b1,1'b1,2'd1,8'h00, 1'b0,8'h00, 1'b0,1'b1,8'h03, 1'b0,8'h00, 1'b0);
        vecs[32] = mk(1'b1,1'b1,2'd0,8'h00, 1'b0,8'h00, 1'b0,1'b1,8'hD4, 1'b0,8'h00, 1'b0);
        vecs[33] = mk(1'b1,1'b1,2'd1,8'h00, 1'b0,8'h00, 1'b0,1'b1,8'h02, 1'b0,8'h00, 1'b0);
        vecs[34] = mk(1'b0,1'b0,2'd0,8'h00, 1'b1,8'hE5, 1'b0,1'b0,8'h00, 1'b0,8'h00, 1'b1);
        vecs[35] = mk(1'b0,1'b0,2'd0,8'h00, 1'b0,8'h00, 1'b0,1'b0,8'h00, 1'b0,8'h00, 1'b0);
        vecs[36] = mk(1'b1,1'b0,2'd1,8'h04, 1'b1,8'hF6, 1'b0,1'b0,8'h00, 1'b0,8'h00, 1'b1);
        vecs[37] = mk(1'b1,1'b1,2'd1,8'h00, 1'b0,8'h00, 1'b0,1'b1,8'h07, 1'b0,8'h00, 1'b0);
        vecs[38] = mk(1'b1,1'b0,2'd1,8'h04, 1'b0,8'h00, 1'b0,1'b0,8'h00, 1'b0,8'h00, 1'b0);
        vecs[39] = mk(1'b1,1'b1,2'd1,8'h00, 1'b0,8'h00, 1'b0,1'b1,8'h03, 1'b0,8'h00, 1'b0);
        vecs[40] = mk(1'b0,1'b0,2'd0,8'h00, 1'b0,8'h00, 1'b0,1'b1,8'h03, 1'b0,8'h00, 1'b0);
        vecs[41] = mk(1'b0,1'b1,2'd0,8'h00, 1'b0,8'h00, 1'b0,1'b1,8'h03, 1'b0,8'h00, 1'b0);
        vecs[42] = mk(1'b1,1'b1,2'd1,8'h00, 1'b0,8'h00, 1'b0,1'b1,8'h03, 1'b0,8'h00, 1'b0);

        @(posedge clk); @(posedge clk); #1;
        chk("rst_rd_data", {8'h00, rd_data}, 16'h0000);
        chk("rst_brg_en", {15'd0, brg_en}, 16'h0000);
        chk("rst_clr_rdy", {15'd0, clr_rdy}, 16'h0000);
        chk("rst_tx_start", {15'd0, tx_start}, 16'h0000);
        chk("rst_tx_data", {8'h00, tx_data}, 16'h0000);
        rst = 1'b0;

        for (int i = 0; i < NV; i++) begin
            iocs = vecs[i].iocs; iorw = vecs[i].iorw; ioaddr = vecs[i].addr;
            wr_data = vecs[i].wd; rx_rdy = vecs[i].rxr; rx_data = vecs[i].rxd;
            tx_busy = vecs[i].busy;
            @(posedge clk); #1;
            chk($sformatf("v%0d_tx_start", i), {15'd0, tx_start}, {15'd0, vecs[i].exp_txs});
            chk($sformatf("v%0d_clr_rdy", i), {15'd0, clr_rdy}, {15'd0, vecs[i].exp_clr});
            if (vecs[i].exp_txs)
                chk($sformatf("v%0d_tx_data", i), {8'h00, tx_data}, {8'h00, vecs[i].exp_txd});
            if (vecs[i].chk_rd)
                chk($sformatf("v%0d_rd_data", i), {8'h00, rd_data}, {8'h00, vecs[i].exp_rd});
        end
        idle_bus();
        rx_rdy = 1'b0; tx_busy = 1'b0;

        // Default divisor period
        wait_tick(400, n);
        chk("brg_first_default", {15'd0, n != -1}, 16'h0001);
        wait_tick(400, n);
        chk("brg_period_325", n[15:0], 16'd325);

        // Divisor 4: first tick 4 cycles after reload, then every 4
        bus_wr(2'd2, 8'h04);
        bus_wr(2'd3, 8'h00);
        wait_tick(20, n);
        chk("brg_d4_first", n[15:0], 16'd4);
        wait_tick(20, n);
        chk("brg_d4_period_a", n[15:0], 16'd4);
        wait_tick(20, n);
        chk("brg_d4_period_b", n[15:0], 16'd4);

        // Reload landing on the expiry cycle suppresses that tick
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
        end
        bus_wr(2'd3, 8'h00);
        chk("brg_expiry_suppressed", {15'd0, brg_en}, 16'h0000);
        wait_tick(20, n);
        chk("brg_expiry_restart", n[15:0], 16'd4);

        // Divisor 0 holds the strobe low
        bus_wr(2'd2, 8'h00);
        ticks = 0;
        for (int k = 0; k < 100; k++) begin
            @(posedge clk); #1;
            if (brg_en === 1'b1) ticks++;
        end
        chk("brg_d0_no_ticks", ticks[15:0], 16'd0);
        bus_rd(2'd2, rd);
        chk("div_lo_readback", {8'h00, rd}, 16'h0000);

        // Reset with a byte held behind a busy transmitter
        tx_busy = 1'b1;
        bus_wr(2'd0, 8'h77);
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        chk("async_rst_rd_data", {8'h00, rd_data}, 16'h0000);
        @(posedge clk); #1;
        rst = 1'b0;
        tx_busy = 1'b0;
        starts = 0;
        for (int k = 0; k < 10; k++) begin
            @(posedge clk); #1;
            if (tx_start === 1'b1) starts++;
        end
        chk("no_start_after_rst", starts[15:0], 16'd0);
        bus_rd(2'd1, rd);
        chk("rst_status", {8'h00, rd}, 16'h0002);
        bus_rd(2'd2, rd);
        chk("rst_div_lo", {8'h00, rd}, 16'h0045);
        bus_rd(2'd3, rd);
        chk("rst_div_hi", {8'h00, rd}, 16'h0001);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/spart_ctrl.md
# spart_ctrl

Bus-side controller for the SPART UART: decodes a 2-bit processor I/O bus and sequences the receiver and transmitter. Generates the 16x-oversample `brg_en` strobe from a programmable divisor. Owns a one-byte receive buffer and a one-byte transmit holding register. Sits between the processor bus and the `UART_rx` / UART transmitter instances, and is the only block that drives `clr_rdy`, `tx_start` and `brg_en`.

## Interface
Parameters:
- `DEFAULT_DIV`, 16'd325, divisor loaded at reset (50 MHz, 9600 baud, 16x).

Ports:
- `clk`  in  1  system clock
- `rst`  in  1  asynchronous, active-high reset
- `iocs`  in  1  bus chip select; one access per cycle when high
- `iorw`  in  1  1 = read, 0 = write
- `ioaddr`  in  2  register address
- `wr_data`  in  8  bus write data
- `rd_data`  out  8  bus read data, registered
- `brg_en`  out  1  one-cycle baud tick to rx/tx
- `rx_rdy`  in  1  receiver byte-ready
- `rx_data`  in  8  receiver byte
- `clr_rdy`  out  1  one-cycle clear to receiver
- `tx_busy`  in  1  transmitter shifting
- `tx_start`  out  1  one-cycle launch to transmitter
- `tx_data`  out  8  byte to transmit, valid while `tx_start` high

## Operation
- Register map, write (iocs & !iorw):
  - addr 0: load TX hold if `tbr`=1, else drop byte and set `tx_ovr`.
  - addr 1: W1C; bit2 clears `rx_ovr`, bit3 clears `tx_ovr`.
  - addr 2: divisor[7:0]; addr 3: divisor[15:8]. Either write reloads BRG counter.
- Register map, read (iocs & iorw):
  - addr 0: `rx_buf`; clears `rbr`.
  - addr 1: status {lb, 3'b0, tx_ovr, rx_ovr, tbr, rbr}.
  - addr 2/3: divisor low/high byte.
- BRG: 16-bit down counter. For divisor D ≥ 1, `brg_en` pulses one cycle every D cycles. D = 0 holds `brg_en` low.
- RX capture:
  - rising edge of `rx_rdy`, detected against a registered copy, latches `rx_data` into `rx_buf`, sets `rbr`, and pulses `clr_rdy` in the same cycle.
  - If `rbr` was already 1, the new byte overwrites `rx_buf` and `rx_ovr` sets.
- TX FSM, states EMPTY, FULL, START, GUARD:
  - EMPTY -> FULL on accepted write.
  - FULL -> START when `tx_busy`=0.
  - START drives `tx_start`=1 and `tx_data`=hold for one cycle -> GUARD.
  - GUARD ignores `tx_busy` for one cycle -> EMPTY.
  - `tbr` = (state == EMPTY).

## Timing
- Reset values:
  - `rd_data`=0, `brg_en`=0, `clr_rdy`=0, `tx_start`=0, `tx_data`=0.
  - divisor=DEFAULT_DIV, counter=DEFAULT_DIV-1.
  - `rbr`=0, `tbr`=1, both ovr=0, TX state EMPTY, lb=0.
- Read latency: `rd_data` valid the cycle after the access. Side effects (clear `rbr`) take effect at that same edge. `rd_data` holds its value until the next read.
- TX latency: write to addr 0 with tx idle -> `tx_start` high exactly 2 cycles later (FULL, then START). Next write accepted 4 cycles after the first.
- `clr_rdy` is high the cycle `rx_rdy` is first seen high. A held `rx_rdy` is not recaptured.
- Simultaneous events:
  - Read addr 0 in the same cycle as a capture: returns the old `rx_buf`; `rbr` ends 1; no `rx_ovr`.
  - W1C of an ovr bit in the same cycle as its set condition: set wins.
  - Divisor write in the same cycle as counter expiry: no `brg_en` that cycle; counter restarts at new D-1.
- `iocs` low: no side effects. Undefined addresses do not exist (2-bit map is full).
- Reset mid-operation: all state returns to reset values immediately. Any held TX byte is lost. No `tx_start` is issued after reset deasserts until a new write.

## Configuration
- `SPART_CTRL_LOOPBACK_EN` defined:
  - write addr 1 bit7 sets/clears `lb`; status bit7 reads `lb`.
  - While `lb`=1, START does not assert `tx_start`; instead the hold byte is captured into `rx_buf` under the normal capture rules (`rbr`, `rx_ovr`). External `rx_rdy` edges are ignored; `clr_rdy` is still pulsed on them.
- Not defined: bit7 ignored on write, reads 0; no loopback logic present.

## Test plan
- Reset, read addr 1, addr 2, addr 3 -> 0x02, 0x45, 0x01; `brg_en` period 325 cycles.
- Write D=4 (addr 2=0x04, addr 3=0x00) -> `brg_en` every 4 cycles, first tick 4 cycles after reload; D=0 -> no ticks for 100 cycles.
- Write 0x5A to addr 0 with `tx_busy`=0 -> `tx_start` one cycle, 2 cycles later, `tx_data`=0x5A.
- Write 0x11 then 0x22 back-to-back -> 0x22 dropped, status 0x08. Write 0x08 to addr 1 -> status 0x02.
- Hold `tx_busy`=1, write 0x33 -> no `tx_start` until `tx_busy` falls; status `tbr`=0 throughout.
- Two `rx_rdy` pulses (0xA1, 0xB2) with no read -> `clr_rdy` pulsed twice, status 0x07. Read addr 0 -> 0xB2, then status 0x06.
